// File: rtl/system_bus_ctrl.sv
// 6502 system bus controller: phi generation, CPU reset stretch, address decode, ROM wait states,
// read-data mux and memory-mapped LED/key port. Define TIMER_IRQ_EN to add the interval timer.
module system_bus_ctrl #(
    parameter int                CLK_DIV  = 50,
    parameter int                ADDR_W   = 16,
    parameter int                RES_HOLD = 8,
    parameter logic [ADDR_W-1:0] ROM_BASE = 16'hF000,
    parameter logic [ADDR_W-9:0] IO_PAGE  = 8'hD0,
    parameter int                ROM_WAIT = 1,
    parameter int                LED_W    = 18
) (
    input  logic              CLOCK_50,
    input  logic              res_n,
    output logic              phi,
    output logic              phi_fall,
    output logic              cpu_res,
    input  logic [ADDR_W-1:0] ab,
    input  logic [7:0]        dbo,
    input  logic              rw,
    output logic              rdy,
    output logic [7:0]        dbi,
    output logic              ram_cs,
    output logic              ram_we,
    output logic              rom_cs,
    input  logic [7:0]        ram_rdata,
    input  logic [7:0]        rom_rdata,
    input  logic [3:0]        key,
    output logic [LED_W-1:0]  led,
    output logic              irq_n
);
    localparam int                CNT_W     = $clog2(CLK_DIV);
    localparam int                HOLD_W    = $clog2(RES_HOLD + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLK_DIV / 2);
    localparam logic [CNT_W-1:0]  CNT_DBI   = CNT_W'(CLK_DIV - 2);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RES_HOLD - 1);
    localparam logic [3:0]        WAIT_LOAD = 4'(ROM_WAIT);

    logic [CNT_W-1:0]  cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [3:0]        wcnt;
    logic              waited;
    logic              io_sel;
    logic              io_wr;
    logic [7:0]        io_off;
    logic [7:0]        rd_data;
    logic [3:0]        key_meta;
    logic [3:0]        key_sync;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50 or negedge res_n) begin
        if (!res_n)        cnt <= '0;
        else if (phi_fall) cnt <= '0;
        else               cnt <= cnt + 1'b1;
    end

    assign phi      = (cnt >= CNT_HALF);
    assign phi_fall = (cnt == CNT_LAST);

    // CPU reset is released in the cycle after the RES_HOLD-th phi_fall.
    always_ff @(posedge CLOCK_50 or negedge res_n) begin
        if (!res_n) begin
            hold_cnt <= '0;
            cpu_res  <= 1'b1;
        end else if (phi_fall && cpu_res) begin
            if (hold_cnt == HOLD_LAST) cpu_res  <= 1'b0;
            else                       hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign io_sel = (ab[ADDR_W-1:8] == IO_PAGE);
    assign rom_cs = !io_sel && (ab >= ROM_BASE);
    assign ram_cs = !io_sel && !rom_cs;
    assign ram_we = phi_fall && ram_cs && !rw;
    assign io_off = ab[7:0];
    assign io_wr  = phi_fall && io_sel && !rw;

    // waited marks the bus cycle that has already served its wait states, so it is not re-stalled.
    always_ff @(posedge CLOCK_50 or negedge res_n) begin
        if (!res_n) begin
            wcnt   <= '0;
            rdy    <= 1'b1;
            waited <= 1'b0;
        end else begin
            if ((ROM_WAIT > 0) && (cnt == CNT_HALF) && rom_cs && rw && rdy && !waited) begin
                wcnt <= WAIT_LOAD;
                rdy  <= 1'b0;
            end
            if (phi_fall) begin
                if (wcnt != 4'd0) begin
                    wcnt <= wcnt - 4'd1;
                    if (wcnt == 4'd1) begin
                        rdy    <= 1'b1;
                        waited <= 1'b1;
                    end
                end else if (rdy) begin
                    waited <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge res_n) begin
        if (!res_n) begin
            key_meta <= '0;
            key_sync <= '0;
        end else begin
            key_meta <= key;
            key_sync <= key_meta;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge res_n) begin
        if (!res_n) begin
            led <= '0;
        end else if (io_wr) begin
            case (io_off)
                8'h00:   led[7:0]         <= dbo;
                8'h01:   led[15:8]        <= dbo;
                8'h02:   led[LED_W-1:16]  <= dbo[LED_W-17:0];
                default: ;
            endcase
        end
    end

`ifdef TIMER_IRQ_EN
    logic [15:0] tmr_reload;
    logic [15:0] tmr_cnt;
    logic        tmr_run;
    logic        tmr_ien;
    logic        tmr_flag;
    logic        io_rd_commit;

    assign io_rd_commit = phi_fall && io_sel && rw && rdy;

    always_ff @(posedge CLOCK_50 or negedge res_n) begin
        if (!res_n) begin
            tmr_reload <= '0;
            tmr_cnt    <= '0;
            tmr_run    <= 1'b0;
            tmr_ien    <= 1'b0;
            tmr_flag   <= 1'b0;
        end else begin
            if (io_wr && io_off == 8'h04) tmr_reload[7:0]  <= dbo;
            if (io_wr && io_off == 8'h05) tmr_reload[15:8] <= dbo;
            if (io_wr && io_off == 8'h06) begin
                tmr_run <= dbo[0];
                tmr_ien <= dbo[1];
            end
            if (io_wr && io_off == 8'h06 && dbo[0] && !tmr_run) begin
                tmr_cnt <= tmr_reload;
            end else if (phi_fall && tmr_run) begin
                if (tmr_cnt == 16'd0) tmr_cnt <= tmr_reload;
                else                  tmr_cnt <= tmr_cnt - 16'd1;
            end
            // A terminal count in the same cycle as a status access keeps the flag set.
            if (phi_fall && tmr_run && tmr_cnt == 16'd0)
                tmr_flag <= 1'b1;
            else if (io_off == 8'h07 && (io_wr || io_rd_commit))
                tmr_flag <= 1'b0;
        end
    end

    assign irq_n = !(tmr_flag && tmr_ien);
`else
    assign irq_n = 1'b1;
`endif

    // NOTE: default assignment first so no path through this block infers a latch.
    always_comb begin
        rd_data = 8'h00;
        if (io_sel) begin
            case (io_off)
                8'h00:   rd_data = led[7:0];
                8'h01:   rd_data = led[15:8];
                8'h02:   rd_data = 8'(led[LED_W-1:16]);
                8'h03:   rd_data = {4'h0, key_sync};
`ifdef TIMER_IRQ_EN
                8'h04:   rd_data = tmr_reload[7:0];
                8'h05:   rd_data = tmr_reload[15:8];
                8'h06:   rd_data = {6'h00, tmr_ien, tmr_run};
                8'h07:   rd_data = {7'h00, tmr_flag};
`endif
                default: rd_data = 8'h00;
            endcase
        end else if (rom_cs) begin
            rd_data = rom_rdata;
        end else begin
            rd_data = ram_rdata;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge res_n) begin
        if (!res_n)              dbi <= '0;
        else if (cnt == CNT_DBI) dbi <= rd_data;
    end

endmodule

// File: tb/tb_system_bus_ctrl.sv
// Directed bench for system_bus_ctrl (CLK_DIV=50, ROM_WAIT=2, LED_W=18); timer checks follow TIMER_IRQ_EN.
module tb_system_bus_ctrl;
    localparam int CLK_DIV = 50;

    logic        clk = 1'b0;
    logic        res_n;
    logic        phi, phi_fall, cpu_res, rdy;
    logic [15:0] ab;
    logic [7:0]  dbo, dbi, ram_rdata, rom_rdata;
    logic        rw, ram_cs, ram_we, rom_cs, irq_n;
    logic [3:0]  key;
    logic [17:0] led;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    system_bus_ctrl #(.CLK_DIV(CLK_DIV), .ROM_WAIT(2)) dut (
        .CLOCK_50 (clk),
        .res_n    (res_n),
        .phi      (phi),
        .phi_fall (phi_fall),
        .cpu_res  (cpu_res),
        .ab       (ab),
        .dbo      (dbo),
        .rw       (rw),
        .rdy      (rdy),
        .dbi      (dbi),
        .ram_cs   (ram_cs),
        .ram_we   (ram_we),
        .rom_cs   (rom_cs),
        .ram_rdata(ram_rdata),
        .rom_rdata(rom_rdata),
        .key      (key),
        .led      (led),
        .irq_n    (irq_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; releases reset and follows the stretch through to cpu_res falling.
    task automatic release_and_check();
        int pf = 0;
        res_n = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (phi_fall) pf++;
            if (n == 24)  check("phi_low_cnt24", phi, 1'b0);
            if (n == 25)  check("phi_high_cnt25", phi, 1'b1);
            if (n == 399) begin
                check("cpu_res_held", cpu_res, 1'b1);
                check("hold_pulses", pf, 8);
            end
            if (n == 400) check("cpu_res_fall", cpu_res, 1'b0);
        end
    endtask

    // Called at the negedge with cnt==0; returns at the next cnt==0 negedge after the commit edge.
    task automatic bus_access(input logic [15:0] a, input logic r, input logic [7:0] d,
                              output logic [7:0] rd, output int we_n, output int stall_n);
        int n = 0;
        we_n    = 0;
        stall_n = 0;
        ab = a; rw = r; dbo = d;
        forever begin
            @(negedge clk);
            n++;
            if (ram_we) we_n++;
            if (!rdy)   stall_n++;
            if ((phi_fall && rdy) || n >= 20 * CLK_DIV) break;
        end
        if (!(phi_fall && rdy)) check("access_timeout", {phi_fall, rdy}, 2'b11);
        rd = dbi;
        @(negedge clk);
        ab = 16'h0000; rw = 1'b1; dbo = 8'h00;
    endtask

    task automatic step_period();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!phi_fall && n < 4 * CLK_DIV);
        if (!phi_fall) check("period_timeout", phi_fall, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] rd;
        int we_n, stall_n;
        int hi = 0, pf = 0, bad = 0, last = -2;

        res_n = 1'b0; ab = 16'h0000; dbo = 8'h00; rw = 1'b1;
        ram_rdata = 8'h11; rom_rdata = 8'h5A; key = 4'hA;

        // Reset values and reset stretch
        repeat (10) @(negedge clk);
        check("rst_cpu_res", cpu_res, 1'b1);
        check("rst_phi", {phi, phi_fall}, 2'b00);
        check("rst_led", led, 18'h0);
        check("rst_rdy_irq", {rdy, irq_n}, 2'b11);
        check("rst_dbi", dbi, 8'h00);
        release_and_check();

        // 1000 free-running phi periods; first phi_fall at n=48 since sample n sees cnt=(n+1)%50
        for (int n = 0; n < 1000 * CLK_DIV; n++) begin
            @(negedge clk);
            if (phi) hi++;
            if (phi_fall) begin
                if (n - last != CLK_DIV) bad++;
                last = n;
                pf++;
            end
        end
        check("phi_high_cycles", hi, 25000);
        check("phi_fall_count", pf, 1000);
        check("phi_fall_spacing", bad, 0);

        // ROM read with two wait states, stepped cycle by cycle from cnt==0
        ab = 16'hFFFC; rw = 1'b1;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            case (k)
                25:  check("rom_rdy_pre", rdy, 1'b1);
                26:  check("rom_rdy_stall", rdy, 1'b0);
                47:  check("rom_dbi_hold", dbi, 8'h11);
                49:  check("rom_pf1", {phi_fall, rdy}, 2'b10);
                99:  check("rom_pf2", {phi_fall, rdy}, 2'b10);
                100: check("rom_rdy_back", rdy, 1'b1);
                126: check("rom_no_restall", rdy, 1'b1);
                149: begin
                    check("rom_pf3", {phi_fall, rdy}, 2'b11);
                    check("rom_dbi", dbi, 8'h5A);
                end
                default: ;
            endcase
        end
        ab = 16'h0000;
        rom_rdata = 8'hC3;
        bus_access(16'hF000, 1'b1, 8'h00, rd, we_n, stall_n);
        check("rom2_data", rd, 8'hC3);
        check("rom2_stall_cycles", stall_n, 74);

        // Decode boundaries, all inside the cnt==0 low phase
        ab = 16'h0200; #1 check("dec_ram", {ram_cs, rom_cs}, 2'b10);
        ab = 16'hD0FF; #1 check("dec_io", {ram_cs, rom_cs}, 2'b00);
        ab = 16'hEFFF; #1 check("dec_ram_top", {ram_cs, rom_cs}, 2'b10);
        ab = 16'hF000; #1 check("dec_rom_base", {ram_cs, rom_cs}, 2'b01);
        ab = 16'h0000;

        // LED writes, RAM write strobe, ignored ROM write, read-back
        bus_access(16'hD000, 1'b0, 8'hA5, rd, we_n, stall_n);
        check("io_wr_no_we", we_n, 0);
        bus_access(16'hD001, 1'b0, 8'h3C, rd, we_n, stall_n);
        bus_access(16'hD002, 1'b0, 8'h02, rd, we_n, stall_n);
        check("led_value", led, 18'h23CA5);
        bus_access(16'h0200, 1'b0, 8'h77, rd, we_n, stall_n);
        check("ram_we_pulses", we_n, 1);
        check("ram_wr_stall", stall_n, 0);
        bus_access(16'hF000, 1'b0, 8'hFF, rd, we_n, stall_n);
        check("rom_wr_we", we_n, 0);
        check("rom_wr_stall", stall_n, 0);
        check("led_after_rom_wr", led, 18'h23CA5);
        bus_access(16'hD000, 1'b1, 8'h00, rd, we_n, stall_n);
        check("rd_led_lo", rd, 8'hA5);
        bus_access(16'hD001, 1'b1, 8'h00, rd, we_n, stall_n);
        check("rd_led_mid", rd, 8'h3C);
        bus_access(16'hD002, 1'b1, 8'h00, rd, we_n, stall_n);
        check("rd_led_hi", rd, 8'h02);
        bus_access(16'hD003, 1'b1, 8'h00, rd, we_n, stall_n);
        check("rd_key", rd, 8'h0A);
        bus_access(16'hD0FE, 1'b1, 8'h00, rd, we_n, stall_n);
        check("rd_unmapped", rd, 8'h00);
        bus_access(16'h0200, 1'b1, 8'h00, rd, we_n, stall_n);
        check("rd_ram", rd, 8'h11);
        check("rd_ram_stall", stall_n, 0);

`ifdef TIMER_IRQ_EN
        // Load 3 and start: 3->2->1->0, then the 4th phi_fall reloads and raises the flag
        bus_access(16'hD004, 1'b0, 8'h03, rd, we_n, stall_n);
        bus_access(16'hD005, 1'b0, 8'h00, rd, we_n, stall_n);
        bus_access(16'hD006, 1'b0, 8'h03, rd, we_n, stall_n);
        for (int i = 1; i <= 4; i++) begin
            step_period();
            check($sformatf("tmr_irq_pf%0d", i), irq_n, (i < 4) ? 1'b1 : 1'b0);
        end
        bus_access(16'hD007, 1'b1, 8'h00, rd, we_n, stall_n);
        check("tmr_status", rd, 8'h01);
        check("tmr_irq_clear", irq_n, 1'b1);
        bus_access(16'hD004, 1'b1, 8'h00, rd, we_n, stall_n);
        check("tmr_reload_rd", rd, 8'h03);
`else
        bus_access(16'hD004, 1'b0, 8'h03, rd, we_n, stall_n);
        bus_access(16'hD006, 1'b0, 8'h03, rd, we_n, stall_n);
        bus_access(16'hD004, 1'b1, 8'h00, rd, we_n, stall_n);
        check("notmr_rd04", rd, 8'h00);
        bus_access(16'hD006, 1'b1, 8'h00, rd, we_n, stall_n);
        check("notmr_rd06", rd, 8'h00);
        step_period();
        step_period();
        check("notmr_irq", irq_n, 1'b1);
`endif

        // Reset asserted in the middle of a ROM wait
        ab = 16'hFFFC; rw = 1'b1;
        repeat (60) @(negedge clk);
        check("midwait_rdy", rdy, 1'b0);
        res_n = 1'b0;
        #1;
        check("abort_rdy", rdy, 1'b1);
        check("abort_led", led, 18'h0);
        check("abort_irq", irq_n, 1'b1);
        check("abort_cpu_res", cpu_res, 1'b1);
        repeat (5) @(negedge clk);
        ab = 16'h0000;
        release_and_check();
        bus_access(16'hD000, 1'b0, 8'h5C, rd, we_n, stall_n);
        check("restart_led", led, 18'h0005C);
        bus_access(16'hFFFC, 1'b1, 8'h00, rd, we_n, stall_n);
        check("restart_rom_data", rd, 8'hC3);
        check("restart_rom_stall", stall_n, 74);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
